traffic_light_ctrl: RTL and testbench



---
 rtl/traffic_light_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with programmable phases, pedestrian early
// termination of road A green and a night flashing mode. Optional macro: ALL_RED_EN.
module traffic_light_ctrl #(
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned GREEN_A     = 8,
  parameter int unsigned GREEN_B     = 10,
  parameter int unsigned YELLOW      = 3,
  parameter int unsigned MIN_GREEN_A = 4,
  parameter int unsigned FLASH_HALF  = 2,
  parameter int unsigned ALL_RED     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       night,
  output logic [2:0] light_a,
  output logic [2:0] light_b,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] GREEN_A_C     = CNT_W'(GREEN_A);
  localparam logic [CNT_W-1:0] GREEN_B_C     = CNT_W'(GREEN_B);
  localparam logic [CNT_W-1:0] YELLOW_C      = CNT_W'(YELLOW);
  localparam logic [CNT_W-1:0] MIN_GREEN_A_C = CNT_W'(MIN_GREEN_A);
  localparam logic [CNT_W-1:0] FLASH_HALF_C  = CNT_W'(FLASH_HALF);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    B_GRN = 3'd2,
    B_YEL = 3'd3,
`ifdef ALL_RED_EN
    NIGHT = 3'd4,
    A_CLR = 3'd5,
    B_CLR = 3'd6
`else
    NIGHT = 3'd4
`endif
  } state_e;

`ifdef ALL_RED_EN
  localparam logic [CNT_W-1:0] ALL_RED_C = CNT_W'(ALL_RED);
`else
  // Clearance length has no meaning without the CLR states.
  logic unused_all_red;
  assign unused_all_red = ^ALL_RED;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ped_pending_q, ped_pending_d;
  logic             flash_q, flash_d;
  logic [2:0]       light_a_q, light_a_d;
  logic [2:0]       light_b_q, light_b_d;
  logic             ped_walk_q, ped_walk_d;

  // Phase sequencing; count is 1 on the first cycle of every state.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q + CNT_ONE;
    flash_d       = flash_q;
    ped_pending_d = ped_pending_q;

    if (ped_req && (state_q != B_GRN)) ped_pending_d = 1'b1;

    case (state_q)
      A_GRN: begin
        if ((count_q == GREEN_A_C) || (ped_pending_q && (count_q >= MIN_GREEN_A_C))) begin
          state_d       = A_YEL;
          count_d       = CNT_ONE;
          ped_pending_d = 1'b0;
        end
      end
      A_YEL: begin
        if (count_q == YELLOW_C) begin
          count_d = CNT_ONE;
`ifdef ALL_RED_EN
          state_d = A_CLR;
`else
          state_d = night ? NIGHT : B_GRN;
`endif
        end
      end
      B_GRN: begin
        if (count_q == GREEN_B_C) begin
          state_d = B_YEL;
          count_d = CNT_ONE;
        end
      end
      B_YEL: begin
        if (count_q == YELLOW_C) begin
          count_d = CNT_ONE;
`ifdef ALL_RED_EN
          state_d = B_CLR;
`else
          state_d = night ? NIGHT : A_GRN;
`endif
        end
      end
`ifdef ALL_RED_EN
      A_CLR: begin
        if (count_q == ALL_RED_C) begin
          count_d = CNT_ONE;
          state_d = night ? NIGHT : B_GRN;
        end
      end
      B_CLR: begin
        if (count_q == ALL_RED_C) begin
          count_d = CNT_ONE;
          state_d = night ? NIGHT : A_GRN;
        end
      end
`endif
      NIGHT: begin
        if (!night) begin
          state_d = A_GRN;
          count_d = CNT_ONE;
          flash_d = 1'b0;
        end else if (count_q == FLASH_HALF_C) begin
          flash_d = ~flash_q;
          count_d = CNT_ONE;
        end
      end
      default: begin
        state_d = A_GRN;
        count_d = CNT_ONE;
        flash_d = 1'b0;
      end
    endcase
  end

  // Lamp decode of the upcoming state so the lamp flops line up with state_q.
  always_comb begin
    light_a_d  = LAMP_RED;
    light_b_d  = LAMP_RED;
    ped_walk_d = 1'b0;
    case (state_d)
      A_GRN: light_a_d = LAMP_GRN;
      A_YEL: light_a_d = LAMP_YEL;
      B_GRN: begin
        light_b_d  = LAMP_GRN;
        ped_walk_d = 1'b1;
      end
      B_YEL: light_b_d = LAMP_YEL;
      NIGHT: begin
        light_a_d = flash_d ? LAMP_YEL : LAMP_OFF;
        light_b_d = flash_d ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= A_GRN;
      count_q       <= CNT_ONE;
      ped_pending_q <= 1'b0;
      flash_q       <= 1'b0;
      light_a_q     <= LAMP_GRN;
      light_b_q     <= LAMP_RED;
      ped_walk_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      ped_pending_q <= ped_pending_d;
      flash_q       <= flash_d;
      light_a_q     <= light_a_d;
      light_b_q     <= light_b_d;
      ped_walk_q    <= ped_walk_d;
    end
  end

  assign light_a  = light_a_q;
  assign light_b  = light_b_q;
  assign ped_walk = ped_walk_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: fixed cycle, pedestrian request, night
// mode, mid-phase reset, then a random safety sweep. Honours ALL_RED_EN if defined.
module tb_traffic_light_ctrl;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] D = 3'b000;

  logic       clk = 1'b0;
  logic       reset;
  logic       ped_req;
  logic       night;
  logic [2:0] light_a;
  logic [2:0] light_b;
  logic       ped_walk;
  logic [2:0] phase;

  int vectors     = 0;
  int miscompares = 0;

  traffic_light_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .ped_req  (ped_req),
    .night    (night),
    .light_a  (light_a),
    .light_b  (light_b),
    .ped_walk (ped_walk),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed ph/a/b/walk=%b required %b", tag, idx, obs, exp);
    end
  endtask

  // Check n consecutive cycles of one phase, advancing one clock after each.
  task automatic expect_run(input string tag, input logic [2:0] ph, input logic [2:0] la,
                            input logic [2:0] lb, input logic pw, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, i + 1, {phase, light_a, light_b, ped_walk}, {ph, la, lb, pw});
      tick();
    end
  endtask

  task automatic exp_agrn(input string tag, input int n); expect_run(tag, 3'd0, G, R, 1'b0, n); endtask
  task automatic exp_ayel(input string tag, input int n); expect_run(tag, 3'd1, Y, R, 1'b0, n); endtask
  task automatic exp_bgrn(input string tag, input int n); expect_run(tag, 3'd2, R, G, 1'b1, n); endtask
  task automatic exp_byel(input string tag, input int n); expect_run(tag, 3'd3, R, Y, 1'b0, n); endtask
  task automatic exp_dark(input string tag, input int n); expect_run(tag, 3'd4, D, D, 1'b0, n); endtask
  task automatic exp_flsh(input string tag, input int n); expect_run(tag, 3'd4, Y, R, 1'b0, n); endtask

  task automatic exp_clr_a(input string tag);
`ifdef ALL_RED_EN
    expect_run(tag, 3'd5, R, R, 1'b0, 1);
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  task automatic exp_clr_b(input string tag);
`ifdef ALL_RED_EN
    expect_run(tag, 3'd6, R, R, 1'b0, 1);
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  initial begin
    int         run;
    logic [2:0] prev;
    logic       safe;

    reset   = 1'b1;
    ped_req = 1'b0;
    night   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Default period: 8/3/10/3 (plus clearance cycles when enabled)
    exp_agrn("p1_agrn", 8);
    exp_ayel("p1_ayel", 3);
    exp_clr_a("p1_aclr");
    exp_bgrn("p1_bgrn", 10);
    exp_byel("p1_byel", 3);
    exp_clr_b("p1_bclr");
    exp_agrn("p2_agrn_c1", 1);

    // Pedestrian pulse on A green cycle 2: green ends after MIN_GREEN_A
    ped_req = 1'b1;
    exp_agrn("ped_c2", 1);
    ped_req = 1'b0;
    exp_agrn("ped_c34", 2);
    exp_ayel("ped_ayel", 3);
    exp_clr_a("ped_aclr");

    // Request during B green is ignored
    exp_bgrn("bped_pre", 2);
    ped_req = 1'b1;
    exp_bgrn("bped_c3", 1);
    ped_req = 1'b0;
    exp_bgrn("bped_post", 7);
    exp_byel("bped_byel", 3);
    exp_clr_b("bped_bclr");

    // Night raised mid A green: green and yellow finish first
    exp_agrn("ngt_agrn_a", 4);
    night = 1'b1;
    exp_agrn("ngt_agrn_b", 4);
    exp_ayel("ngt_ayel", 3);
    exp_clr_a("ngt_aclr");
    exp_dark("ngt_dark1", 2);
    exp_flsh("ngt_flsh1", 2);
    exp_dark("ngt_dark2", 2);
    exp_flsh("ngt_flsh2", 2);
    night = 1'b0;
    exp_dark("ngt_exit", 1);
    exp_agrn("ngt_agrn_full", 8);
    exp_ayel("ngt_ayel2", 3);
    exp_clr_a("ngt_aclr2");

    // Reset on B green cycle 5 aborts straight to A green
    exp_bgrn("rst_bgrn", 4);
    reset = 1'b1;
    exp_bgrn("rst_bgrn_c5", 1);
    reset = 1'b0;
    exp_agrn("rst_agrn", 8);
    exp_ayel("rst_ayel", 3);
    exp_clr_a("rst_aclr");

    // Random sweep: one road red outside NIGHT, yellow always exactly 3 cycles
    prev = phase;
    run  = 0;
    for (int c = 0; c < 1000; c++) begin
      safe = (phase == 3'd4) || (light_a == R) || (light_b == R);
      check("rnd_safe", c, {9'd0, safe}, 10'd1);
      if (phase == prev) begin
        run++;
      end else begin
        if ((prev == 3'd1) || (prev == 3'd3)) check("rnd_yel_len", c, 10'(run), 10'd3);
        run = 1;
      end
      prev    = phase;
      ped_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) night = ~night;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
